// File: rtl/matrix_stream_storage_if.sv
// matrix_stream_storage_if: write, clear and read channels of matrix_stream_storage.
// The rd_parity_err signal exists only when MATRIX_STREAM_STORAGE_PARITY_EN is defined.
interface matrix_stream_storage_if #(
  parameter int DATA_W = 48,
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // write port
  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic              wr_auto;
  logic [IDX_W-1:0]  wr_layer_index;
  logic [IDX_W-1:0]  wr_row_index;
  logic [DATA_W-1:0] wr_data;
  logic              wr_error;
  logic              locator_reset;
  // clear engine
  logic              clr_req;
  logic [CH_W-1:0]   clr_ch;
  logic              clr_busy;
  // read port
  logic              rd_valid;
  logic [CH_W-1:0]   rd_ch;
  logic [IDX_W-1:0]  rd_layer_index;
  logic [IDX_W-1:0]  rd_row_index;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_error;
  logic [NUM_CH-1:0] ch_full;
`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
  logic              rd_parity_err;
`endif

  modport master (
    output wr_valid, wr_ch, wr_auto, wr_layer_index, wr_row_index, wr_data,
           locator_reset, clr_req, clr_ch,
           rd_valid, rd_ch, rd_layer_index, rd_row_index,
    input  wr_ready, wr_error, clr_busy, rd_data_valid, rd_data, rd_error, ch_full
`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
    , input rd_parity_err
`endif
  );

  modport slave (
    input  wr_valid, wr_ch, wr_auto, wr_layer_index, wr_row_index, wr_data,
           locator_reset, clr_req, clr_ch,
           rd_valid, rd_ch, rd_layer_index, rd_row_index,
    output wr_ready, wr_error, clr_busy, rd_data_valid, rd_data, rd_error, ch_full
`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
    , output rd_parity_err
`endif
  );
endinterface

// File: rtl/matrix_stream_storage.sv
// matrix_stream_storage: NUM_CH matrix channels of LAYERS x ROWS words, with
// explicit or auto-locator writes, a per-channel clear engine and a 1-cycle
// read port. Optional per-word even parity: MATRIX_STREAM_STORAGE_PARITY_EN.
module matrix_stream_storage #(
  parameter int DATA_W = 48,
  parameter int LAYERS = 4,
  parameter int ROWS   = 16,
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  matrix_stream_storage_if.slave bus
);
  localparam int DEPTH = LAYERS * ROWS;
  localparam int AW    = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int RW    = (ROWS   > 1) ? $clog2(ROWS)   : 1;

  typedef enum logic {IDLE, CLEAR} clr_state_e;
  clr_state_e state, state_nxt;

  logic [AW-1:0]     clr_addr;
  logic [CH_W-1:0]   clr_ch_q;
  logic              clr_busy, clr_start, clr_last, clr_ch_ok;

  logic              wr_ch_ok, wr_idx_ok, wr_blk_clr, wr_blk_full;
  logic              wr_ready, wr_acc, wr_commit, wr_drop, wr_error_q;
  logic [CH_W-1:0]   wr_ch_sel;
  logic [AW-1:0]     wr_addr, wr_exp_addr;

  logic              rd_ch_ok, rd_idx_ok, rd_bad;
  logic [CH_W-1:0]   rd_ch_sel;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid_q, rd_error_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [NUM_CH-1:0] full_v;
  logic [AW-1:0]     loc_addr_v [NUM_CH];
  logic [DATA_W-1:0] rd_word_v  [NUM_CH];
`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
  logic              rd_par_v   [NUM_CH];
  logic              rd_par_err_q;
`endif

  // ---------------- write decode ----------------
  assign wr_ch_ok    = 32'(bus.wr_ch) < 32'(NUM_CH);
  assign wr_ch_sel   = wr_ch_ok ? bus.wr_ch : '0;
  assign wr_idx_ok   = (bus.wr_layer_index < IDX_W'(LAYERS)) &&
                       (bus.wr_row_index   < IDX_W'(ROWS));
  assign wr_exp_addr = AW'(bus.wr_layer_index[LW-1:0]) * AW'(ROWS) +
                       AW'(bus.wr_row_index[RW-1:0]);

  assign wr_blk_clr  = clr_busy && (bus.wr_ch == clr_ch_q);
  assign wr_blk_full = bus.wr_auto && wr_ch_ok && full_v[wr_ch_sel];
  // Held low during reset so every output reads 0 while reset is asserted.
  assign wr_ready    = reset_reset_n && !wr_blk_clr && !wr_blk_full;
  assign wr_acc      = bus.wr_valid && wr_ready;
  // A locator_reset in the same cycle discards an auto write; explicit writes proceed.
  assign wr_commit   = wr_acc && wr_ch_ok && (bus.wr_auto ? !bus.locator_reset : wr_idx_ok);
  // Auto writes to a full channel are refused by wr_ready but still reported as dropped.
  assign wr_drop     = (wr_acc && !wr_commit) || (bus.wr_valid && wr_blk_full);
  assign wr_addr     = bus.wr_auto ? loc_addr_v[wr_ch_sel] : wr_exp_addr;

  // Drop indication, one cycle after the offending request.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) wr_error_q <= 1'b0;
    else                wr_error_q <= wr_drop;
  end

  // ---------------- clear engine ----------------
  assign clr_ch_ok = 32'(bus.clr_ch) < 32'(NUM_CH);
  assign clr_busy  = (state == CLEAR);
  assign clr_start = (state == IDLE) && bus.clr_req && clr_ch_ok;
  assign clr_last  = (clr_addr == AW'(DEPTH - 1));

  // Clear FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Clear FSM next state: one pass over every address, requests ignored while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear address sweep and latched target channel.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      clr_addr <= '0;
      clr_ch_q <= '0;
    end else if (clr_start) begin
      clr_addr <= '0;
      clr_ch_q <= bus.clr_ch;
    end else if (clr_busy) begin
      clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
    end
  end

  // ---------------- read decode ----------------
  assign rd_ch_ok  = 32'(bus.rd_ch) < 32'(NUM_CH);
  assign rd_ch_sel = rd_ch_ok ? bus.rd_ch : '0;
  assign rd_idx_ok = (bus.rd_layer_index < IDX_W'(LAYERS)) &&
                     (bus.rd_row_index   < IDX_W'(ROWS));
  assign rd_bad    = !rd_ch_ok || !rd_idx_ok || (clr_busy && (bus.rd_ch == clr_ch_q));
  assign rd_addr   = AW'(bus.rd_layer_index[LW-1:0]) * AW'(ROWS) +
                     AW'(bus.rd_row_index[RW-1:0]);

  // ---------------- per-channel storage ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [LW-1:0]     loc_layer;
    logic [RW-1:0]     loc_row;
    logic              full;
    logic              clr_this, wr_this, auto_this, loc_clr;

    assign clr_this  = clr_busy && (clr_ch_q == CH_W'(c));
    assign wr_this   = wr_commit && (wr_ch_sel == CH_W'(c));
    assign auto_this = wr_this && bus.wr_auto;
    assign loc_clr   = bus.locator_reset || (clr_start && (bus.clr_ch == CH_W'(c)));

    // Auto-write locator: row-major advance, parks on the last word and flags full.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        loc_layer <= '0;
        loc_row   <= '0;
        full      <= 1'b0;
      end else if (loc_clr) begin
        loc_layer <= '0;
        loc_row   <= '0;
        full      <= 1'b0;
      end else if (auto_this) begin
        if (loc_row == RW'(ROWS - 1)) begin
          if (loc_layer == LW'(LAYERS - 1)) begin
            full <= 1'b1;
          end else begin
            loc_row   <= '0;
            loc_layer <= loc_layer + LW'(1);
          end
        end else begin
          loc_row <= loc_row + RW'(1);
        end
      end
    end

    // Word storage: the clear sweep owns the write port of its channel.
    always_ff @(posedge clk_clk) begin
      if (clr_this)     mem[clr_addr] <= '0;
      else if (wr_this) mem[wr_addr]  <= bus.wr_data;
    end

`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
    logic mem_par [DEPTH];

    // Even-parity bit stored alongside each word; cleared words carry parity 0.
    always_ff @(posedge clk_clk) begin
      if (clr_this)     mem_par[clr_addr] <= 1'b0;
      else if (wr_this) mem_par[wr_addr]  <= ^bus.wr_data;
    end

    assign rd_par_v[c] = mem_par[rd_addr];
`endif

    assign full_v[c]     = full;
    assign loc_addr_v[c] = AW'(loc_layer) * AW'(ROWS) + AW'(loc_row);
    assign rd_word_v[c]  = mem[rd_addr];
  end

  // Registered read response; data holds between responses, error responses return 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_valid_q <= 1'b0;
      rd_error_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_valid;
      rd_error_q <= bus.rd_valid && rd_bad;
      if (bus.rd_valid) rd_data_q <= rd_bad ? '0 : rd_word_v[rd_ch_sel];
    end
  end

`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
  // Parity check on the word being returned.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rd_par_err_q <= 1'b0;
    else rd_par_err_q <= bus.rd_valid && !rd_bad &&
                         ((^rd_word_v[rd_ch_sel]) != rd_par_v[rd_ch_sel]);
  end

  assign bus.rd_parity_err = rd_par_err_q;
`endif

  assign bus.wr_ready      = wr_ready;
  assign bus.wr_error      = wr_error_q;
  assign bus.clr_busy      = clr_busy;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.rd_error      = rd_error_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.ch_full       = full_v;
endmodule

// File: tb/tb_matrix_stream_storage.sv
// tb_matrix_stream_storage: directed stimulus with a linear-address reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_matrix_stream_storage;
  localparam int DATA_W = 48;
  localparam int LAYERS = 4;
  localparam int ROWS   = 16;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = LAYERS * ROWS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_storage_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDX_W(32), .CH_W(2)) bus ();

  matrix_stream_storage #(
    .DATA_W(DATA_W), .LAYERS(LAYERS), .ROWS(ROWS), .NUM_CH(NUM_CH), .IDX_W(32), .CH_W(2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  int checks = 0;
  int fails  = 0;
  int busy_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_mem   [NUM_CH][DEPTH];
  bit                m_known [NUM_CH][DEPTH];
  int                m_loc   [NUM_CH];   // linear next-write position
  bit                m_full  [NUM_CH];
  int                m_clr_left, m_clr_ch;
  bit                e_wr_error, e_rd_valid, e_rd_error, e_rd_known;
  logic [DATA_W-1:0] e_rd_data;

  function automatic bit m_ready();
    int ch;
    ch = int'(bus.wr_ch);
    if (!rst_n) return 1'b0;
    if (m_clr_left > 0 && ch == m_clr_ch) return 1'b0;
    if (bus.wr_auto && ch < NUM_CH && m_full[ch]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_loc[c] = 0; m_full[c] = 0;
        for (int a = 0; a < DEPTH; a++) m_known[c][a] = 0;
      end
      m_clr_left = 0; m_clr_ch = 0;
      e_wr_error = 0; e_rd_valid = 0; e_rd_error = 0; e_rd_known = 1; e_rd_data = '0;
    end else begin
      bit busy, rdy, bad;
      int wch, rch, a;
      busy = m_clr_left > 0;
      rdy  = m_ready();
      // read sees contents before this edge's writes
      e_rd_valid = bus.rd_valid;
      e_rd_error = 0;
      if (bus.rd_valid) begin
        rch = int'(bus.rd_ch);
        bad = rch >= NUM_CH || bus.rd_layer_index >= LAYERS || bus.rd_row_index >= ROWS ||
              (busy && rch == m_clr_ch);
        e_rd_error = bad;
        if (bad) begin
          e_rd_data = '0; e_rd_known = 1;
        end else begin
          a = int'(bus.rd_layer_index) * ROWS + int'(bus.rd_row_index);
          e_rd_data = m_mem[rch][a]; e_rd_known = m_known[rch][a];
        end
      end
      // write
      e_wr_error = 0;
      wch = int'(bus.wr_ch);
      if (bus.wr_valid) begin
        if (!rdy) begin
          if (bus.wr_auto && wch < NUM_CH && m_full[wch]) e_wr_error = 1;
        end else if (wch >= NUM_CH) begin
          e_wr_error = 1;
        end else if (bus.wr_auto) begin
          if (bus.locator_reset) e_wr_error = 1;
          else begin
            m_mem[wch][m_loc[wch]] = bus.wr_data;
            m_known[wch][m_loc[wch]] = 1;
            if (m_loc[wch] == DEPTH - 1) m_full[wch] = 1;
            else m_loc[wch]++;
          end
        end else if (bus.wr_layer_index >= LAYERS || bus.wr_row_index >= ROWS) begin
          e_wr_error = 1;
        end else begin
          a = int'(bus.wr_layer_index) * ROWS + int'(bus.wr_row_index);
          m_mem[wch][a] = bus.wr_data; m_known[wch][a] = 1;
        end
      end
      if (bus.locator_reset)
        for (int c = 0; c < NUM_CH; c++) begin m_loc[c] = 0; m_full[c] = 0; end
      // clear: channel reads as zero once finished; reads during it are errors
      if (busy) m_clr_left--;
      else if (bus.clr_req && int'(bus.clr_ch) < NUM_CH) begin
        m_clr_ch = int'(bus.clr_ch);
        m_clr_left = DEPTH;
        m_loc[m_clr_ch] = 0; m_full[m_clr_ch] = 0;
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[m_clr_ch][i] = '0; m_known[m_clr_ch][i] = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("wr_error", 64'(bus.wr_error), 64'(e_wr_error));
      chk("wr_ready", 64'(bus.wr_ready), 64'(m_ready()));
      chk("rd_data_valid", 64'(bus.rd_data_valid), 64'(e_rd_valid));
      chk("rd_error", 64'(bus.rd_error), 64'(e_rd_error));
      if (e_rd_known) chk("rd_data", 64'(bus.rd_data), 64'(e_rd_data));
      chk("clr_busy", 64'(bus.clr_busy), 64'(m_clr_left > 0));
      chk("ch_full", 64'(bus.ch_full), 64'({m_full[2], m_full[1], m_full[0]}));
    end
  end

  always @(posedge clk) if (bus.clr_busy) busy_cycles++;

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.wr_valid = 0; bus.wr_ch = '0; bus.wr_auto = 0; bus.wr_layer_index = '0;
    bus.wr_row_index = '0; bus.wr_data = '0; bus.locator_reset = 0;
    bus.clr_req = 0; bus.clr_ch = '0;
    bus.rd_valid = 0; bus.rd_ch = '0; bus.rd_layer_index = '0; bus.rd_row_index = '0;
  endtask

  task automatic wr_exp(input int ch, input int l, input int r, input logic [DATA_W-1:0] d);
    @(negedge clk); idle();
    bus.wr_valid = 1; bus.wr_ch = 2'(ch); bus.wr_layer_index = 32'(l);
    bus.wr_row_index = 32'(r); bus.wr_data = d;
  endtask

  task automatic aw(input int ch, input logic [DATA_W-1:0] d, input bit lr);
    @(negedge clk); idle();
    bus.wr_valid = 1; bus.wr_auto = 1; bus.wr_ch = 2'(ch); bus.wr_data = d; bus.locator_reset = lr;
  endtask

  task automatic rd(input int ch, input int l, input int r);
    @(negedge clk); idle();
    bus.rd_valid = 1; bus.rd_ch = 2'(ch); bus.rd_layer_index = 32'(l); bus.rd_row_index = 32'(r);
  endtask

  task automatic rsp();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_ready", 64'(bus.wr_ready), 0);
    chk("reset_wr_error", 64'(bus.wr_error), 0);
    chk("reset_clr_busy", 64'(bus.clr_busy), 0);
    chk("reset_rd_valid", 64'(bus.rd_data_valid), 0);
    chk("reset_rd_data", 64'(bus.rd_data), 0);
    chk("reset_ch_full", 64'(bus.ch_full), 0);
    @(negedge clk); rst_n = 1;

    // explicit write and read back
    wr_exp(1, 2, 5, 48'h123456789ABC);
    wr_exp(1, 0, 0, 48'h000000000AAA);
    wr_exp(1, 3, 15, 48'h000000000BBB);
    rd(1, 2, 5); rsp();
    chk("explicit_rd_valid", 64'(bus.rd_data_valid), 1);
    chk("explicit_rd_data", 64'(bus.rd_data), 64'h123456789ABC);
    chk("explicit_rd_error", 64'(bus.rd_error), 0);

    // auto fill of channel 0
    for (int i = 0; i < DEPTH; i++) aw(0, 48'(i), 0);
    @(negedge clk); idle();
    bus.wr_valid = 1; bus.wr_auto = 1; bus.wr_ch = 2'd0; bus.wr_data = 48'hFFFF;
    #1;
    chk("fill_ch_full0", 64'(bus.ch_full[0]), 1);
    chk("fill_65th_ready", 64'(bus.wr_ready), 0);
    rsp();
    chk("fill_65th_error", 64'(bus.wr_error), 1);
    rd(0, 3, 15); rsp(); chk("fill_rd_3_15", 64'(bus.rd_data), 63);
    rd(0, 1, 3);  rsp(); chk("fill_rd_1_3", 64'(bus.rd_data), 19);

    // locator_reset colliding with an auto write on channel 2
    wr_exp(2, 0, 3, 48'd55);
    aw(2, 48'd100, 0); aw(2, 48'd101, 0); aw(2, 48'd102, 0);
    aw(2, 48'hDEAD, 1); rsp();
    chk("locrst_wr_error", 64'(bus.wr_error), 1);
    aw(2, 48'd200, 0);
    rd(2, 0, 3); rsp(); chk("locrst_not_written", 64'(bus.rd_data), 55);
    rd(2, 0, 0); rsp(); chk("locrst_lands_0_0", 64'(bus.rd_data), 200);
    rd(2, 0, 1); rsp(); chk("locrst_keeps_0_1", 64'(bus.rd_data), 101);

    // out-of-range accesses
    wr_exp(1, 0, 16, 48'h1); rsp();
    chk("oor_row_wr_error", 64'(bus.wr_error), 1);
    wr_exp(3, 0, 0, 48'h2);
    rd(1, 4, 0); rsp();
    chk("oor_layer_rd_valid", 64'(bus.rd_data_valid), 1);
    chk("oor_layer_rd_error", 64'(bus.rd_error), 1);
    chk("oor_layer_rd_data", 64'(bus.rd_data), 0);

    // refill channel 0 partly, then clear it
    for (int i = 0; i < 5; i++) aw(0, 48'(i + 500), 0);
    @(negedge clk); idle(); bus.clr_req = 1; bus.clr_ch = 2'd0; busy_cycles = 0;
    rd(0, 0, 0); rsp();
    chk("clear_busy_high", 64'(bus.clr_busy), 1);
    chk("clear_rd_error", 64'(bus.rd_error), 1);
    @(negedge clk); idle();
    for (int k = 0; k < 200 && bus.clr_busy; k++) @(negedge clk);
    chk("clear_timeout", 64'(bus.clr_busy), 0);
    chk("clear_busy_cycles", 64'(busy_cycles), 64);
    for (int i = 0; i < DEPTH; i++) rd(0, i / ROWS, i % ROWS);
    rsp();
    chk("clear_last_word", 64'(bus.rd_data), 0);
    chk("clear_ch_full0", 64'(bus.ch_full[0]), 0);
    rd(1, 2, 5);  rsp(); chk("clear_ch1_kept", 64'(bus.rd_data), 64'h123456789ABC);
    rd(1, 3, 15); rsp(); chk("clear_ch1_kept2", 64'(bus.rd_data), 64'hBBB);
    aw(0, 48'h77, 0);
    rd(0, 0, 0); rsp(); chk("clear_loc_restart", 64'(bus.rd_data), 64'h77);

    // asynchronous reset in the middle of a clear
    @(negedge clk); idle(); bus.clr_req = 1; bus.clr_ch = 2'd1;
    @(negedge clk); idle();
    repeat (10) @(negedge clk);
    #3; rst_n = 0; #1;
    chk("midrst_clr_busy", 64'(bus.clr_busy), 0);
    chk("midrst_wr_ready", 64'(bus.wr_ready), 0);
    chk("midrst_rd_data", 64'(bus.rd_data), 0);
    chk("midrst_ch_full", 64'(bus.ch_full), 0);
    @(negedge clk); rst_n = 1;
    aw(0, 48'h99, 0);
    rd(0, 0, 0); rsp(); chk("midrst_loc_0_0", 64'(bus.rd_data), 64'h99);

`ifdef MATRIX_STREAM_STORAGE_PARITY_EN
    begin
      logic bad_par;
      wr_exp(1, 2, 5, 48'h123456789ABC);
      rd(1, 2, 5); rsp(); chk("parity_clean", 64'(bus.rd_parity_err), 0);
      bad_par = ~(^48'h123456789ABC);
      force dut.g_ch[1].mem_par[37] = bad_par;
      rd(1, 2, 5); rsp(); chk("parity_forced", 64'(bus.rd_parity_err), 1);
      release dut.g_ch[1].mem_par[37];
    end
`endif

    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
